// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package mc_pkg;

    // One state per datapath cycle.
    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        TRAP
    } statetype_t;

    // ALU operation requested by the FSM.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Opcodes (Instr[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUControl encodings.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Result mux select.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand selects.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate format select.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/mc_alu_decode.sv
// ALU control decode: maps ALUOp/funct3/funct7b5 to the ALU operation and
// flags funct3 values this core does not implement.
module mc_alu_decode
    import mc_pkg::*;
(
    input  aluop_t      alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        opb5,
    output logic [2:0]  alu_control,
    output logic        bad_funct
);

    // Select the ALU operation; unsupported funct3 falls back to add and raises bad_funct.
    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 & opb5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: bad_funct   = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Control FSM for the multicycle RV32I datapath (shared instr/data memory).
// Optional performance counters are built when MC_CTRL_PERF_EN is defined;
// otherwise cycle_cnt and instret_cnt are tied to zero.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    statetype_t state, next_state;
    aluop_t     alu_op;
    logic       bad_funct;

    mc_alu_decode u_alu_decode (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .opb5        (op[5]),
        .alu_control (alu_control),
        .bad_funct   (bad_funct)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Next-state and Moore outputs (pc_write in BRANCH and mem_ready gating excepted).
    // illegal is sticky because TRAP is only left through reset.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_WD;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    default:           next_state = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                imm_src    = op[5] ? IMM_S : IMM_I;
                next_state = op[5] ? MEMWR : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            EXECR: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_WD;
                alu_op     = ALUOP_FUNCT;
                next_state = bad_funct ? TRAP : ALUWB;
            end
            EXECI: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_I;
                alu_op     = ALUOP_FUNCT;
                next_state = bad_funct ? TRAP : ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_WD;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero ^ funct3[0];
                next_state = FETCH;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                imm_src    = IMM_J;
                next_state = ALUWB;
            end
            TRAP: begin
                illegal    = 1'b1;
                next_state = TRAP;
            end
            default: next_state = FETCH;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             retire;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    // An instruction retires in its final state; a store only once memory accepts it.
    always_comb begin
        retire = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                 ((state == MEMWR) && mem_ready);
    end

    // Free-running cycle and retired-instruction counters, wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_ONE;
            if (retire) instret_q <= instret_q + CNT_ONE;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. Expected per-cycle control words are
// derived from the instruction's class and the memory wait pattern.
module tb_mc_controller;

    localparam int unsigned CNT_W = 32;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0]       result_src, alu_src_a, alu_src_b;
    logic [2:0]       imm_src, alu_control;
    logic             illegal;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [2:0] alu_control;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic rdy;
        logic z;
        ctl_t exp;
        logic ret;
    } cyc_t;

    ctl_t obs;
    assign obs = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};

    cyc_t             q[$];
    int unsigned      n_chk = 0;
    int unsigned      n_fail = 0;
    logic [CNT_W-1:0] m_cyc;
    logic [CNT_W-1:0] m_ret;
    string            tag;
    logic             trapped;

    // ---------------- expected control words, one per kind of cycle ----------------
    function automatic ctl_t c_fetch(logic r);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
        c.ir_write = r; c.pc_write = r;
        return c;
    endfunction

    function automatic ctl_t c_decode();
        ctl_t c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 3'b010;
        return c;
    endfunction

    function automatic ctl_t c_memadr(logic is_store);
        ctl_t c = '0;
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
        c.imm_src = is_store ? 3'b001 : 3'b000;
        return c;
    endfunction

    function automatic ctl_t c_mem(logic wr);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = wr;
        return c;
    endfunction

    function automatic ctl_t c_wb(logic from_mem);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.result_src = from_mem ? 2'b01 : 2'b00;
        return c;
    endfunction

    function automatic ctl_t c_exec(logic is_r, logic [2:0] aluc);
        ctl_t c = '0;
        c.alu_src_a = 2'b10; c.alu_src_b = is_r ? 2'b00 : 2'b01;
        c.alu_control = aluc;
        return c;
    endfunction

    function automatic ctl_t c_branch(logic pcw);
        ctl_t c = '0;
        c.alu_src_a = 2'b10; c.alu_control = 3'b001; c.pc_write = pcw;
        return c;
    endfunction

    function automatic ctl_t c_jal();
        ctl_t c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; c.imm_src = 3'b011;
        return c;
    endfunction

    function automatic ctl_t c_trap();
        ctl_t c = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

    // Returns {unsupported, alu operation} for an R/I arithmetic instruction.
    function automatic logic [3:0] exp_alu(logic [2:0] f3, logic f7, logic is_r);
        case (f3)
            3'd0:    return {1'b0, (is_r && f7) ? 3'b001 : 3'b000};
            3'd2:    return 4'b0101;
            3'd4:    return 4'b0100;
            3'd6:    return 4'b0011;
            3'd7:    return 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string name, logic [63:0] o, logic [63:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, o, e);
        end
    endtask

    task automatic check_cycle(string name, ctl_t e);
        chk({name, "/ctl"}, 64'(obs), 64'(e));
`ifdef MC_CTRL_PERF_EN
        chk({name, "/cycle_cnt"}, 64'(cycle_cnt), 64'(m_cyc));
        chk({name, "/instret_cnt"}, 64'(instret_cnt), 64'(m_ret));
`else
        chk({name, "/cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        chk({name, "/instret_cnt"}, 64'(instret_cnt), 64'd0);
`endif
    endtask

    task automatic push(logic r, logic z, ctl_t c, logic ret);
        cyc_t e;
        e.rdy = r; e.z = z; e.exp = c; e.ret = ret;
        q.push_back(e);
    endtask

    // Build the cycle-by-cycle expectation for one instruction.
    task automatic build(logic [6:0] opc, logic [2:0] f3, logic f7,
                         int unsigned fw, int unsigned mw, logic zb, output logic traps);
        logic [3:0] a;
        logic       is_r;
        traps    = 1'b0;
        op       = opc;
        funct3   = f3;
        funct7b5 = f7;
        for (int unsigned i = 0; i < fw; i++) push(1'b0, 1'($urandom_range(0, 1)), c_fetch(1'b0), 1'b0);
        push(1'b1, 1'($urandom_range(0, 1)), c_fetch(1'b1), 1'b0);
        push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_decode(), 1'b0);
        if (opc == LW || opc == SW) begin
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_memadr(opc == SW), 1'b0);
            for (int unsigned i = 0; i < mw; i++) push(1'b0, 1'($urandom_range(0, 1)), c_mem(opc == SW), 1'b0);
            push(1'b1, 1'($urandom_range(0, 1)), c_mem(opc == SW), opc == SW);
            if (opc == LW) push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_wb(1'b1), 1'b1);
        end else if (opc == RT || opc == IT) begin
            is_r = (opc == RT);
            a = exp_alu(f3, f7, is_r);
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_exec(is_r, a[2:0]), 1'b0);
            if (a[3]) traps = 1'b1;
            else push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_wb(1'b0), 1'b1);
        end else if (opc == BR) begin
            push(1'($urandom_range(0, 1)), zb, c_branch(zb ^ f3[0]), 1'b1);
        end else if (opc == JL) begin
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_jal(), 1'b0);
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_wb(1'b0), 1'b1);
        end else begin
            traps = 1'b1;
        end
        if (traps)
            for (int unsigned i = 0; i < 3; i++)
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_trap(), 1'b0);
    endtask

    // Apply the first n queued cycles (entered and left at a falling edge).
    task automatic run(int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            mem_ready = q[i].rdy;
            zero      = q[i].z;
            #1;
            check_cycle($sformatf("%s[%0d]", tag, i), q[i].exp);
            @(posedge clk);
            m_cyc = m_cyc + 1'b1;
            if (q[i].ret) m_ret = m_ret + 1'b1;
            @(negedge clk);
        end
        q.delete();
    endtask

    task automatic run_all();
        run(q.size());
    endtask

    // Asynchronous reset: outputs must fall back to FETCH before any clock edge.
    task automatic do_reset(string name);
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        m_cyc     = '0;
        m_ret     = '0;
        #1;
        check_cycle({name, "/async"}, c_fetch(1'b0));
        @(posedge clk);
        @(negedge clk);
        check_cycle({name, "/hold"}, c_fetch(1'b0));
        reset = 1'b0;
    endtask

    logic [6:0] bad_ops [6] = '{7'h7f, 7'h37, 7'h17, 7'h67, 7'h73, 7'h00};
    logic [6:0] good_ops[6] = '{LW, SW, RT, IT, BR, JL};

    initial begin
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        m_cyc = '0; m_ret = '0;
        @(negedge clk);
        do_reset("por");

        tag = "lw";       build(LW, 3'b010, 1'b0, 0, 0, 1'b0, trapped); run_all();
        tag = "sw_wait3"; build(SW, 3'b010, 1'b0, 0, 3, 1'b0, trapped); run_all();
        tag = "lw_after"; build(LW, 3'b010, 1'b0, 1, 1, 1'b0, trapped); run_all();
        tag = "beq_z1";   build(BR, 3'b000, 1'b0, 0, 0, 1'b1, trapped); run_all();
        tag = "bne_z1";   build(BR, 3'b001, 1'b0, 0, 0, 1'b1, trapped); run_all();
        tag = "beq_z0";   build(BR, 3'b000, 1'b0, 0, 0, 1'b0, trapped); run_all();
        tag = "jal";      build(JL, 3'b000, 1'b0, 0, 0, 1'b0, trapped); run_all();
        tag = "sub";      build(RT, 3'b000, 1'b1, 0, 0, 1'b0, trapped); run_all();
        tag = "addi_f7";  build(IT, 3'b000, 1'b1, 0, 0, 1'b0, trapped); run_all();

        tag = "bad_op";   build(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, trapped); run_all();
        do_reset("trap_reset");
        tag = "sll_trap"; build(RT, 3'b001, 1'b0, 0, 0, 1'b0, trapped); run_all();
        do_reset("funct_reset");

        // Abort a store while mem_write is asserted: fetch, decode, memadr, 4 waits.
        tag = "sw_abort"; build(SW, 3'b010, 1'b0, 0, 6, 1'b0, trapped); run(7);
        do_reset("memwr_reset");

        for (int unsigned i = 0; i < 150; i++) begin
            logic [6:0] opc;
            if ($urandom_range(0, 19) == 0) opc = bad_ops[$urandom_range(0, 5)];
            else                            opc = good_ops[$urandom_range(0, 5)];
            tag = $sformatf("rnd%0d", i);
            build(opc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), trapped);
            run_all();
            if (trapped) do_reset($sformatf("rnd%0d_reset", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
